// File: rtl/vx_packet_merge_pkg.sv
// ---------------------------------------------------------------------------
// vx_packet_merge_pkg
// Shared definitions for the packet merge block:
//   - default warp geometry macros (SIMD_WIDTH, XLEN) when not supplied
//   - merge-state encoding (IDLE / COLLECT / FULL)
//   - packet-id width helper, never narrower than one bit
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef SIMD_WIDTH
`define SIMD_WIDTH 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

package vx_packet_merge_pkg;

    typedef logic [1:0] merge_state_t;

    localparam merge_state_t MERGE_IDLE    = 2'd0;
    localparam merge_state_t MERGE_COLLECT = 2'd1;
    localparam merge_state_t MERGE_FULL    = 2'd2;

    // Width of a packet index; a single-packet warp still carries a 1-bit pid.
    function automatic int pid_width(input int num_packets);
        if (num_packets > 1) begin
            return $clog2(num_packets);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/vx_packet_merge_if.sv
// ---------------------------------------------------------------------------
// vx_packet_merge_if
// Handshake bundle between a lane-sliced result producer and the merged
// warp-wide consumer.
//   Input side  : valid_in, ready_in, data_in, tmask_in, result_in, pid_in,
//                 sop_in, eop_in
//   Output side : valid_out, ready_out, data_out, tmask_out, result_out,
//                 err_out
// Modports: slave  = the merge block, master = the environment around it.
// ---------------------------------------------------------------------------
interface vx_packet_merge_if
    import vx_packet_merge_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int DATAW     = 1
);
    localparam int NUM_PACKETS = `SIMD_WIDTH / NUM_LANES;
    localparam int PID_WIDTH   = pid_width(NUM_PACKETS);

    logic                            valid_in;
    logic                            ready_in;
    logic [DATAW-1:0]                data_in;
    logic [NUM_LANES-1:0]            tmask_in;
    logic [NUM_LANES*`XLEN-1:0]      result_in;
    logic [PID_WIDTH-1:0]            pid_in;
    logic                            sop_in;
    logic                            eop_in;

    logic                            valid_out;
    logic                            ready_out;
    logic [DATAW-1:0]                data_out;
    logic [`SIMD_WIDTH-1:0]          tmask_out;
    logic [`SIMD_WIDTH*`XLEN-1:0]    result_out;
    logic                            err_out;

    modport slave (
        input  valid_in, data_in, tmask_in, result_in, pid_in, sop_in, eop_in,
        input  ready_out,
        output ready_in,
        output valid_out, data_out, tmask_out, result_out, err_out
    );

    modport master (
        output valid_in, data_in, tmask_in, result_in, pid_in, sop_in, eop_in,
        output ready_out,
        input  ready_in,
        input  valid_out, data_out, tmask_out, result_out, err_out
    );

endinterface

// File: rtl/vx_packet_merge.sv
// ---------------------------------------------------------------------------
// vx_packet_merge
// Reassembles a warp-wide result from NUM_PACKETS lane-sliced packets.
// Each accepted packet writes its lane slice (selected by pid_in) into the
// tmask/result accumulators; the sop beat clears the rest and captures the
// sideband. After the eop beat the accumulators are presented directly as
// the merged output until the consumer takes them.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : vx_packet_merge_if.slave (input packets in, merged result out)
// Optional build macro:
//   PACKET_MERGE_PROTOCOL_CHK_EN - enables the sticky err_out protocol
//   checker (non-sop start, sop inside an instruction, non-increasing pid).
//   When undefined err_out is tied low and no checker logic exists.
// ---------------------------------------------------------------------------
module vx_packet_merge
    import vx_packet_merge_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int DATAW     = 1
) (
    input  logic              clk,
    input  logic              reset,
    vx_packet_merge_if.slave  bus
);
    localparam int NUM_PACKETS = `SIMD_WIDTH / NUM_LANES;
    localparam int PID_WIDTH   = pid_width(NUM_PACKETS);
    localparam int LANE_BITS   = NUM_LANES * `XLEN;
    localparam int RES_BITS    = `SIMD_WIDTH * `XLEN;

    merge_state_t               r_state;
    merge_state_t               w_state_next;
    logic [DATAW-1:0]           r_data;
    logic [DATAW-1:0]           w_data_next;
    logic [`SIMD_WIDTH-1:0]     r_tmask;
    logic [`SIMD_WIDTH-1:0]     w_tmask_base;
    logic [`SIMD_WIDTH-1:0]     w_tmask_next;
    logic [RES_BITS-1:0]        r_result;
    logic [RES_BITS-1:0]        w_result_base;
    logic [RES_BITS-1:0]        w_result_next;

    logic w_ready_in;
    logic w_fire_in;
    logic w_fire_out;
    logic w_start;

    // A full result only blocks input when the consumer is not draining it.
    assign w_ready_in = (r_state != MERGE_FULL) || bus.ready_out;
    assign w_fire_in  = bus.valid_in && w_ready_in;
    assign w_fire_out = (r_state == MERGE_FULL) && bus.ready_out;
    // Any beat arriving outside COLLECT opens a new instruction, sop or not;
    // a sop inside COLLECT abandons the partial one.
    assign w_start    = w_fire_in && (bus.sop_in || (r_state != MERGE_COLLECT));

    // Next merge state.
    always_comb begin
        w_state_next = r_state;
        if (w_fire_in) begin
            if (bus.eop_in) begin
                w_state_next = MERGE_FULL;
            end else begin
                w_state_next = MERGE_COLLECT;
            end
        end else if (w_fire_out) begin
            w_state_next = MERGE_IDLE;
        end else begin
            w_state_next = r_state;
        end
    end

    // Next accumulator contents: clear on start, then overlay the addressed slice.
    always_comb begin
        w_tmask_base  = r_tmask;
        w_result_base = r_result;
        w_data_next   = r_data;
        if (w_start) begin
            w_tmask_base  = '0;
            w_result_base = '0;
            w_data_next   = bus.data_in;
        end else begin
            w_tmask_base  = r_tmask;
            w_result_base = r_result;
            w_data_next   = r_data;
        end
        w_tmask_next  = w_tmask_base;
        w_result_next = w_result_base;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            if (w_fire_in && (bus.pid_in == PID_WIDTH'(p))) begin
                w_tmask_next[p*NUM_LANES +: NUM_LANES]  = bus.tmask_in;
                w_result_next[p*LANE_BITS +: LANE_BITS] = bus.result_in;
            end else begin
                w_tmask_next[p*NUM_LANES +: NUM_LANES]  = w_tmask_base[p*NUM_LANES +: NUM_LANES];
                w_result_next[p*LANE_BITS +: LANE_BITS] = w_result_base[p*LANE_BITS +: LANE_BITS];
            end
        end
    end

    // State and accumulator registers; the accumulators are the output holding stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= MERGE_IDLE;
            r_data   <= '0;
            r_tmask  <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_data   <= w_data_next;
            r_tmask  <= w_tmask_next;
            r_result <= w_result_next;
        end
    end

    assign bus.ready_in   = w_ready_in;
    assign bus.valid_out  = (r_state == MERGE_FULL);
    assign bus.data_out   = r_data;
    assign bus.tmask_out  = r_tmask;
    assign bus.result_out = r_result;

`ifdef PACKET_MERGE_PROTOCOL_CHK_EN
    logic                 r_err;
    logic [PID_WIDTH-1:0] r_last_pid;
    logic                 w_err_hit;

    // Protocol violation detect for the accepted beat.
    always_comb begin
        w_err_hit = 1'b0;
        if (w_fire_in) begin
            if (r_state != MERGE_COLLECT) begin
                w_err_hit = !bus.sop_in;
            end else begin
                w_err_hit = bus.sop_in || (bus.pid_in <= r_last_pid);
            end
        end else begin
            w_err_hit = 1'b0;
        end
    end

    // Sticky error flag and last accepted pid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_last_pid <= '0;
        end else begin
            r_err <= r_err | w_err_hit;
            if (w_fire_in) begin
                r_last_pid <= bus.pid_in;
            end else begin
                r_last_pid <= r_last_pid;
            end
        end
    end

    assign bus.err_out = r_err;
`else
    assign bus.err_out = 1'b0;
`endif

endmodule
